// File: rtl/button_press_classifier_if.sv
// Key-side bundle for one button_press_classifier: debounced level in, classified events out.
interface button_press_classifier_if;
  logic btn_in;
  logic press_o;
  logic short_pulse;
  logic long_pulse;
  logic double_pulse;
  logic busy;

  modport master (
    output btn_in,
    input  press_o, short_pulse, long_pulse, double_pulse, busy
  );

  modport slave (
    input  btn_in,
    output press_o, short_pulse, long_pulse, double_pulse, busy
  );
endinterface

// File: rtl/button_press_classifier.sv
// Turns one key's debounced level into single-cycle short / long / double press pulses.
module button_press_classifier #(
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned LONG_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES  = 12500000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic                      clk,
  input  logic                      rst_n,
  button_press_classifier_if.slave  bus
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT_GAP  = 3'd2,
    PRESS2    = 3'd3,
    HELD_LONG = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s0;
  logic             s1;
  logic             short_q;
  logic             long_q;
  logic             double_q;
  logic             rise;
  logic             fall;

  // Edges are taken from the registered pair, so btn_in never reaches an output combinationally.
  assign rise = s0 & ~s1;
  assign fall = ~s0 & s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      s0       <= bus.btn_in ^ ACTIVE_LOW;
      s1       <= s0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS1;
            cnt   <= '0;
          end
        end
        PRESS1: begin
          if (fall) begin
            state <= WAIT_GAP;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state  <= HELD_LONG;
            long_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        // A rise on the final gap cycle still wins over the timeout.
        WAIT_GAP: begin
          if (rise) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (cnt == GAP_LAST) begin
            state   <= IDLE;
            short_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESS2: begin
          if (fall) begin
            state    <= IDLE;
            double_q <= 1'b1;
          end else if (cnt == LONG_LAST) begin
            state  <= HELD_LONG;
            long_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD_LONG: begin
          if (fall) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.press_o      = s0;
  assign bus.short_pulse  = short_q;
  assign bus.long_pulse   = long_q;
  assign bus.double_pulse = double_q;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_button_press_classifier.sv
// Randomized bench for button_press_classifier against a press-interval reference model.
module tb_button_press_classifier;

  localparam int unsigned LONG = 20;
  localparam int unsigned GAP  = 8;
  localparam int          MAXN = 1024;
  localparam int          NEVER = 100000;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  button_press_classifier_if bif ();

  button_press_classifier #(
    .ACTIVE_LOW (1'b1),
    .LONG_CYCLES(LONG),
    .GAP_CYCLES (GAP),
    .CNT_W      (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lv[k] = normalized pressed level seen by the design after edge k of a segment
  bit lv     [0:MAXN];
  bit e_short[0:MAXN];
  bit e_long [0:MAXN];
  bit e_dbl  [0:MAXN];
  bit e_busy [0:MAXN];
  int runs[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bif.press_o, bif.short_pulse, bif.long_pulse, bif.double_pulse, bif.busy});
  endfunction

  function automatic int next_rise(input int from, input int n);
    for (int i = from; i <= n; i++)
      if (i >= 1 && lv[i] && !lv[i-1]) return i;
    return -1;
  endfunction

  function automatic int next_fall(input int from, input int n);
    for (int i = from + 1; i <= n; i++)
      if (!lv[i]) return i;
    return n + NEVER;
  endfunction

  function automatic void mark_busy(input int a, input int b);
    for (int i = a; i < b && i <= MAXN; i++) e_busy[i] = 1'b1;
  endfunction

  // Expected pulses derived from press/release durations, one press episode at a time.
  task automatic build_expect(input int n);
    int k, e, f, r, f2;
    for (int i = 0; i <= MAXN; i++) begin
      e_short[i] = 0; e_long[i] = 0; e_dbl[i] = 0; e_busy[i] = 0;
    end
    k = 1;
    while (k <= n) begin
      e = next_rise(k, n);
      if (e < 0) break;
      f = next_fall(e, n);
      if (f - e > int'(LONG)) begin
        if (e + 1 + int'(LONG) <= MAXN) e_long[e + 1 + LONG] = 1'b1;
        mark_busy(e + 1, f + 1);
        k = f + 1;
        continue;
      end
      r = (f <= n) ? next_rise(f + 1, n) : -1;
      if (r >= 0 && r <= f + int'(GAP)) begin
        f2 = next_fall(r, n);
        if (f2 - r > int'(LONG)) begin
          if (r + 1 + int'(LONG) <= MAXN) e_long[r + 1 + LONG] = 1'b1;
        end else if (f2 + 1 <= MAXN) begin
          e_dbl[f2 + 1] = 1'b1;
        end
        mark_busy(e + 1, f2 + 1);
        k = f2 + 1;
      end else begin
        if (f + 1 + int'(GAP) <= MAXN) e_short[f + 1 + GAP] = 1'b1;
        mark_busy(e + 1, f + 1 + GAP);
        k = f + 1;
      end
    end
  endtask

  function automatic int build_lv();
    int idx = 1;
    bit level = 1'b0;
    lv[0] = 1'b0;
    foreach (runs[i]) begin
      for (int j = 0; j < runs[i]; j++) begin
        if (idx <= MAXN) lv[idx] = level;
        idx++;
      end
      level = ~level;
    end
    return (idx - 1 > MAXN) ? MAXN : idx - 1;
  endfunction

  // Entered with rst_n low; leaves with rst_n low again after checking the reset clears everything.
  task automatic run_segment(input int seg, input int trunc);
    int n;
    n = build_lv();
    build_expect(n);
    bif.btn_in = ~lv[1];
    rst_n = 1'b1;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) bif.btn_in = ~lv[k];
      @(posedge clk);
      #1;
      check_eq($sformatf("seg%0d_cyc%0d", seg, k), outs(),
               32'({lv[k], e_short[k], e_long[k], e_dbl[k], e_busy[k]}));
      if (trunc > 0 && k == trunc) break;
    end
    rst_n = 1'b0;
    #1;
    check_eq($sformatf("seg%0d_rst_async", seg), outs(), 32'd0);
    repeat (2) begin
      bif.btn_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    check_eq($sformatf("seg%0d_rst_hold", seg), outs(), 32'd0);
  endtask

  function automatic int pick_press();
    case ($urandom_range(0, 5))
      0:       return $urandom_range(1, 4);
      1:       return $urandom_range(LONG - 1, LONG + 2);
      2:       return $urandom_range(5, LONG - 2);
      3:       return $urandom_range(LONG + 5, 2 * LONG);
      4:       return int'(LONG);
      default: return int'(LONG) - 1;
    endcase
  endfunction

  function automatic int pick_release();
    case ($urandom_range(0, 5))
      0:       return $urandom_range(1, 6);
      1:       return $urandom_range(GAP - 1, GAP + 1);
      2:       return $urandom_range(GAP + 2, 2 * GAP);
      3:       return int'(GAP);
      4:       return int'(GAP) - 1;
      default: return int'(GAP) + 1;
    endcase
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bif.btn_in = 1'b1;

    // Reset holds all outputs low regardless of btn_in activity.
    repeat (4) begin
      @(negedge clk);
      bif.btn_in = ~bif.btn_in;
      #1;
      check_eq("reset_hold", outs(), 32'd0);
    end

    runs = '{12};                          run_segment(0, 0);  // released after reset
    runs = '{3, 5, 20};                    run_segment(1, 0);  // short press
    runs = '{2, 40, 30};                   run_segment(2, 0);  // long press
    runs = '{2, 4, 3, 4, 20};              run_segment(3, 0);  // double press
    runs = '{2, 4, GAP, 4, 20};            run_segment(4, 0);  // rise on last gap cycle
    runs = '{2, 4, GAP + 1, 4, 20};        run_segment(5, 0);  // rise one cycle too late
    runs = '{2, LONG, 15};                 run_segment(6, 0);  // longest short press
    runs = '{2, 4, 3, LONG + 1, 15};       run_segment(7, 0);  // second press goes long
    runs = '{2, 40};                       run_segment(8, 19); // reset at cnt 15 in PRESS1
    runs = '{0, 40, 10};                   run_segment(9, 0);  // held through reset release

    for (int s = 10; s < 26; s++) begin
      runs.delete();
      runs.push_back($urandom_range(0, 3));
      for (int j = 0; j < 10; j++) begin
        runs.push_back(pick_press());
        runs.push_back(pick_release());
      end
      runs.push_back(2 * GAP);
      run_segment(s, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 200) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
